// File: rtl/daten_bus_verteiler.sv
`default_nettype none
// ============================================================================
// Module      : daten_bus_verteiler
// Description : Data-port interconnect between the CPU data interface, the
//               data RAM and a bank of memory-mapped I/O channels.
//               The I/O region is selected by DatenAdresse[IO_BASIS_BIT].
//               Each I/O channel has an output register with
//               write/set/clear/toggle access and a synchronised input.
//               RAM accesses run through a registered handshake with a
//               timeout and a sticky error flag.
//
// Ports       : Clock, Reset (sync, active-low)
//               CPU side : LeseDaten, SchreibeDaten, DatenAdresse, DatenRaus,
//                          DatenRein, DatenGeladen, DatenGespeichert
//               RAM side : RAMLeseDaten, RAMSchreibeDaten, RAMAdresse,
//                          RAMDatenSchreiben, RAMDatenLesen, RAMDatenBereit,
//                          RAMDatenGeschrieben
//               I/O side : AusgangPorts, EingangPorts
//               Status   : Fehler (sticky RAM timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module daten_bus_verteiler #(
    parameter int          RAM_ADRESSBITS = 8,
    parameter int          IO_KANAELE     = 4,
    parameter int          IO_BREITE      = 8,
    parameter int          IO_BASIS_BIT   = 31,
    parameter int          TIMEOUT        = 255,
    parameter logic [31:0] FEHLER_WERT    = 32'hDEADBEEF
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            LeseDaten,
    input  logic                            SchreibeDaten,
    input  logic [31:0]                     DatenAdresse,
    input  logic [31:0]                     DatenRaus,
    output logic [31:0]                     DatenRein,
    output logic                            DatenGeladen,
    output logic                            DatenGespeichert,
    output logic                            RAMLeseDaten,
    output logic                            RAMSchreibeDaten,
    output logic [RAM_ADRESSBITS-1:0]       RAMAdresse,
    output logic [31:0]                     RAMDatenSchreiben,
    input  logic [31:0]                     RAMDatenLesen,
    input  logic                            RAMDatenBereit,
    input  logic                            RAMDatenGeschrieben,
    output logic [IO_KANAELE*IO_BREITE-1:0] AusgangPorts,
    input  logic [IO_KANAELE*IO_BREITE-1:0] EingangPorts,
    output logic                            Fehler
);

    localparam int c_KANALBITS = (IO_KANAELE > 1) ? $clog2(IO_KANAELE) : 1;
    localparam int c_BUSBREITE = IO_KANAELE * IO_BREITE;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_RAM_WARTEN = 2'd1;
    localparam logic [1:0] c_ANTWORT    = 2'd2;
    localparam logic [1:0] c_ENDE       = 2'd3;

    logic [1:0]                r_state;
    logic                      r_istSchreiben;
    logic [31:0]               r_datenRein;
    logic                      r_geladen;
    logic                      r_gespeichert;
    logic                      r_ramLese;
    logic                      r_ramSchreibe;
    logic [RAM_ADRESSBITS-1:0] r_ramAdresse;
    logic [31:0]               r_ramDaten;
    logic [c_BUSBREITE-1:0]    r_ausgang;
    logic [c_BUSBREITE-1:0]    r_sync1;
    logic [c_BUSBREITE-1:0]    r_sync2;
    logic                      r_fehler;
    logic [15:0]               r_zaehler;

    logic                      w_anfrage;
    logic [c_KANALBITS-1:0]    w_kanal;
    logic [1:0]                w_modus;
    logic                      w_kanalGueltig;
    logic [IO_BREITE-1:0]      w_d;
    logic [IO_BREITE-1:0]      w_regAlt;
    logic [IO_BREITE-1:0]      w_eingAlt;
    logic [IO_BREITE-1:0]      w_regNeu;
    logic [IO_BREITE-1:0]      w_ioWert;
    logic [31:0]               w_ioLese;
    logic [16:0]               w_zaehlerNext;
    logic                      w_zeitAus;
    logic                      w_fertig;

    assign w_anfrage      = LeseDaten | SchreibeDaten;
    assign w_kanal        = DatenAdresse[c_KANALBITS-1:0];
    assign w_modus        = DatenAdresse[c_KANALBITS+1:c_KANALBITS];
    assign w_kanalGueltig = int'(w_kanal) < IO_KANAELE;
    assign w_d            = DatenRaus[IO_BREITE-1:0];

    // Select the addressed channel's output register and synchronised input.
    // Out-of-range channels read as zero.
    always_comb begin
        w_regAlt  = '0;
        w_eingAlt = '0;
        for (int k = 0; k < IO_KANAELE; k++) begin
            if (int'(w_kanal) == k) begin
                w_regAlt  = r_ausgang[k*IO_BREITE +: IO_BREITE];
                w_eingAlt = r_sync2[k*IO_BREITE +: IO_BREITE];
            end
        end
    end

    always_comb begin
        w_regNeu = w_regAlt;
        w_ioWert = '0;
        case (w_modus)
            2'b00: begin
                w_regNeu = w_d;
                w_ioWert = w_regAlt;
            end
            2'b01: begin
                w_regNeu = w_regAlt | w_d;
                w_ioWert = w_eingAlt;
            end
            2'b10: w_regNeu = w_regAlt & ~w_d;
            default: w_regNeu = w_regAlt ^ w_d;
        endcase
    end

    assign w_ioLese = 32'(w_ioWert);

    // The counter reaching TIMEOUT aborts the access; done in the same cycle
    // is checked first and wins.
    assign w_zaehlerNext = {1'b0, r_zaehler} + 17'd1;
    assign w_zeitAus     = (w_zaehlerNext == 17'(TIMEOUT));
    assign w_fertig      = r_istSchreiben ? RAMDatenGeschrieben : RAMDatenBereit;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state        <= c_IDLE;
            r_istSchreiben <= 1'b0;
            r_datenRein    <= '0;
            r_geladen      <= 1'b0;
            r_gespeichert  <= 1'b0;
            r_ramLese      <= 1'b0;
            r_ramSchreibe  <= 1'b0;
            r_ramAdresse   <= '0;
            r_ramDaten     <= '0;
            r_ausgang      <= '0;
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_fehler       <= 1'b0;
            r_zaehler      <= '0;
        end else begin
            r_sync1       <= EingangPorts;
            r_sync2       <= r_sync1;
            // Acks are set on entry to ANTWORT and fall back here one cycle later.
            r_geladen     <= 1'b0;
            r_gespeichert <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_anfrage) begin
                        // A simultaneous read and write is treated as a write.
                        r_istSchreiben <= SchreibeDaten;
                        if (DatenAdresse[IO_BASIS_BIT]) begin
                            if (SchreibeDaten) begin
                                for (int k = 0; k < IO_KANAELE; k++) begin
                                    if (w_kanalGueltig && (int'(w_kanal) == k)) begin
                                        r_ausgang[k*IO_BREITE +: IO_BREITE] <= w_regNeu;
                                    end
                                end
                                r_gespeichert <= 1'b1;
                            end else begin
                                r_datenRein <= w_ioLese;
                                r_geladen   <= 1'b1;
                            end
                            r_state <= c_ANTWORT;
                        end else begin
                            r_ramAdresse  <= DatenAdresse[RAM_ADRESSBITS-1:0];
                            r_ramDaten    <= DatenRaus;
                            r_ramLese     <= ~SchreibeDaten;
                            r_ramSchreibe <= SchreibeDaten;
                            r_zaehler     <= '0;
                            r_state       <= c_RAM_WARTEN;
                        end
                    end
                end

                c_RAM_WARTEN: begin
                    r_zaehler <= w_zaehlerNext[15:0];
                    if (w_fertig) begin
                        r_ramLese     <= 1'b0;
                        r_ramSchreibe <= 1'b0;
                        if (r_istSchreiben) begin
                            r_gespeichert <= 1'b1;
                        end else begin
                            r_datenRein <= RAMDatenLesen;
                            r_geladen   <= 1'b1;
                        end
                        r_state <= c_ANTWORT;
                    end else if (w_zeitAus) begin
                        r_ramLese     <= 1'b0;
                        r_ramSchreibe <= 1'b0;
                        r_fehler      <= 1'b1;
                        if (r_istSchreiben) begin
                            r_gespeichert <= 1'b1;
                        end else begin
                            r_datenRein <= FEHLER_WERT;
                            r_geladen   <= 1'b1;
                        end
                        r_state <= c_ANTWORT;
                    end
                end

                c_ANTWORT: begin
                    r_state <= c_ENDE;
                end

                // Requests stay high until the CPU has seen the ack; waiting
                // for both to drop prevents issuing the same access twice.
                c_ENDE: begin
                    if (!LeseDaten && !SchreibeDaten) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign DatenRein         = r_datenRein;
    assign DatenGeladen      = r_geladen;
    assign DatenGespeichert  = r_gespeichert;
    assign RAMLeseDaten      = r_ramLese;
    assign RAMSchreibeDaten  = r_ramSchreibe;
    assign RAMAdresse        = r_ramAdresse;
    assign RAMDatenSchreiben = r_ramDaten;
    assign AusgangPorts      = r_ausgang;
    assign Fehler            = r_fehler;

endmodule
`default_nettype wire

// File: tb/tb_daten_bus_verteiler.sv
`default_nettype none
// ============================================================================
// Module      : tb_daten_bus_verteiler
// Description : Scoreboard testbench for daten_bus_verteiler. Stimulus tasks
//               push the expected ack kind and read data; a monitor pops and
//               compares on every ack. A simple RAM model answers strobes
//               after a programmable delay (0 = never).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_daten_bus_verteiler;

    localparam int c_KANAELE = 3;
    localparam int c_BREITE  = 8;
    localparam int c_BUS     = c_KANAELE * c_BREITE;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               LeseDaten, SchreibeDaten;
    logic [31:0]        DatenAdresse, DatenRaus, DatenRein;
    logic               DatenGeladen, DatenGespeichert;
    logic               RAMLeseDaten, RAMSchreibeDaten;
    logic [7:0]         RAMAdresse;
    logic [31:0]        RAMDatenSchreiben, RAMDatenLesen;
    logic               RAMDatenBereit, RAMDatenGeschrieben;
    logic [c_BUS-1:0]   AusgangPorts, EingangPorts;
    logic               Fehler;

    daten_bus_verteiler #(
        .RAM_ADRESSBITS(8),
        .IO_KANAELE    (c_KANAELE),
        .IO_BREITE     (c_BREITE),
        .IO_BASIS_BIT  (31),
        .TIMEOUT       (4),
        .FEHLER_WERT   (32'hDEADBEEF)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .LeseDaten          (LeseDaten),
        .SchreibeDaten      (SchreibeDaten),
        .DatenAdresse       (DatenAdresse),
        .DatenRaus          (DatenRaus),
        .DatenRein          (DatenRein),
        .DatenGeladen       (DatenGeladen),
        .DatenGespeichert   (DatenGespeichert),
        .RAMLeseDaten       (RAMLeseDaten),
        .RAMSchreibeDaten   (RAMSchreibeDaten),
        .RAMAdresse         (RAMAdresse),
        .RAMDatenSchreiben  (RAMDatenSchreiben),
        .RAMDatenLesen      (RAMDatenLesen),
        .RAMDatenBereit     (RAMDatenBereit),
        .RAMDatenGeschrieben(RAMDatenGeschrieben),
        .AusgangPorts       (AusgangPorts),
        .EingangPorts       (EingangPorts),
        .Fehler             (Fehler)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        istLese;
        logic [31:0] daten;
    } erw_t;

    erw_t sb[$];
    erw_t monErw;
    int   checks   = 0;
    int   failures = 0;

    // RAM model
    logic [31:0] ramSpeicher [0:255];
    bit          ramAktiv      = 1'b1;
    int          ramVerzoegerung = 2;
    int          ramZaehler    = 0;

    task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
        checks++;
        if (ist !== soll) begin
            failures++;
            $display("FAIL %s: ist=%h soll=%h", name, ist, soll);
        end
    endtask

    always @(negedge Clock) begin
        if (ramAktiv) begin
            RAMDatenBereit      = 1'b0;
            RAMDatenGeschrieben = 1'b0;
            if (RAMLeseDaten || RAMSchreibeDaten) begin
                ramZaehler++;
                if (ramZaehler == ramVerzoegerung) begin
                    if (RAMSchreibeDaten) begin
                        ramSpeicher[RAMAdresse] = RAMDatenSchreiben;
                        RAMDatenGeschrieben     = 1'b1;
                    end else begin
                        RAMDatenLesen  = ramSpeicher[RAMAdresse];
                        RAMDatenBereit = 1'b1;
                    end
                end
            end else begin
                ramZaehler = 0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge Clock) begin
        if (Reset === 1'b1 && (DatenGeladen || DatenGespeichert)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unerwartete_quittung: geladen=%b gespeichert=%b soll=keine",
                         DatenGeladen, DatenGespeichert);
            end else begin
                monErw = sb.pop_front();
                pruefe("quittungsart", {30'd0, DatenGeladen, DatenGespeichert},
                       monErw.istLese ? 32'd2 : 32'd1);
                if (monErw.istLese) pruefe("lesedaten", DatenRein, monErw.daten);
            end
        end
    end

    task automatic starte(input logic lesen, input logic schreiben,
                          input logic [31:0] adr, input logic [31:0] daten,
                          input logic [31:0] erwartet);
        erw_t e;
        e.istLese = ~schreiben;
        e.daten   = erwartet;
        sb.push_back(e);
        LeseDaten     = lesen;
        SchreibeDaten = schreiben;
        DatenAdresse  = adr;
        DatenRaus     = daten;
    endtask

    task automatic warteAck(output int zyklen);
        zyklen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clock);
            #1;
            zyklen++;
            if (DatenGeladen || DatenGespeichert) return;
        end
        zyklen = -1;
        checks++;
        failures++;
        $display("FAIL ack_timeout: ist=keine_quittung soll=quittung");
    endtask

    task automatic beende(input int extra);
        @(negedge Clock);
        repeat (extra) @(negedge Clock);
        LeseDaten     = 1'b0;
        SchreibeDaten = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
    endtask

    task automatic zugriff(input string name, input logic lesen, input logic schreiben,
                           input logic [31:0] adr, input logic [31:0] daten,
                           input logic [31:0] erwartet, input int latenz);
        int z;
        starte(lesen, schreiben, adr, daten, erwartet);
        warteAck(z);
        if (latenz > 0) pruefe({name, "_latenz"}, z, latenz);
        beende(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: ist=laeuft soll=beendet");
        $fatal(1, "watchdog");
    end

    initial begin
        int z;
        for (int i = 0; i < 256; i++) ramSpeicher[i] = 32'd0;
        Reset = 1'b0;
        LeseDaten = 1'b0; SchreibeDaten = 1'b0;
        DatenAdresse = '0; DatenRaus = '0;
        RAMDatenLesen = '0; RAMDatenBereit = 1'b0; RAMDatenGeschrieben = 1'b0;
        EingangPorts = '0;
        repeat (3) @(negedge Clock);
        pruefe("reset_ausgang", 32'(AusgangPorts), 32'h0);
        pruefe("reset_acks_strobes",
               {28'd0, DatenGeladen, DatenGespeichert, RAMLeseDaten, RAMSchreibeDaten}, 32'h0);
        pruefe("reset_datenrein", DatenRein, 32'h0);
        pruefe("reset_fehler", 32'(Fehler), 32'h0);
        Reset = 1'b1;
        @(negedge Clock);

        // I/O write / readback on channel 0
        zugriff("io_schreib", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_00A5, 32'h0, 1);
        pruefe("ausgang_k0", 32'(AusgangPorts), 32'h00_00A5);
        zugriff("io_lese", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_00A5, 1);

        // Set / clear / toggle on channel 1
        zugriff("k1_schreib", 1'b0, 1'b1, 32'h8000_0001, 32'hF0, 32'h0, 1);
        pruefe("k1_f0", 32'(AusgangPorts), 32'h00_F0A5);
        zugriff("k1_setze", 1'b0, 1'b1, 32'h8000_0005, 32'h0F, 32'h0, 1);
        pruefe("k1_ff", 32'(AusgangPorts), 32'h00_FFA5);
        zugriff("k1_loesche", 1'b0, 1'b1, 32'h8000_0009, 32'h3C, 32'h0, 1);
        pruefe("k1_c3", 32'(AusgangPorts), 32'h00_C3A5);
        zugriff("k1_kippe", 1'b0, 1'b1, 32'h8000_000D, 32'hFF, 32'h0, 1);
        pruefe("k1_3c", 32'(AusgangPorts), 32'h00_3CA5);

        // Out-of-range channel and unused read modes
        zugriff("k3_schreib", 1'b0, 1'b1, 32'h8000_0003, 32'h77, 32'h0, 1);
        pruefe("k3_ignoriert", 32'(AusgangPorts), 32'h00_3CA5);
        zugriff("k3_lese", 1'b1, 1'b0, 32'h8000_0003, 32'h0, 32'h0, 1);
        zugriff("modus10_lese", 1'b1, 1'b0, 32'h8000_0009, 32'h0, 32'h0, 1);

        // RAM write then read, done after 2 cycles
        ramVerzoegerung = 2;
        starte(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0);
        @(posedge Clock); #1;
        pruefe("ram_strobe_schreib", {30'd0, RAMLeseDaten, RAMSchreibeDaten}, 32'd1);
        pruefe("ram_adresse", 32'(RAMAdresse), 32'h10);
        pruefe("ram_schreibdaten", RAMDatenSchreiben, 32'h1234_5678);
        warteAck(z);
        pruefe("ram_schreib_latenz", z, 2);
        beende(0);
        zugriff("ram_lese", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3);
        pruefe("fehler_vor_timeout", 32'(Fehler), 32'h0);

        // RAM never answers
        ramVerzoegerung = 0;
        starte(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF);
        warteAck(z);
        pruefe("timeout_nach_timeout", 32'(z > 4), 32'h1);
        pruefe("timeout_strobe_aus", {30'd0, RAMLeseDaten, RAMSchreibeDaten}, 32'd0);
        pruefe("fehler_gesetzt", 32'(Fehler), 32'h1);
        beende(0);
        ramVerzoegerung = 1;
        zugriff("ram_lese_nach_fehler", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 2);
        pruefe("fehler_bleibt", 32'(Fehler), 32'h1);

        // Read and write together: write wins, held requests do not re-issue
        starte(1'b1, 1'b1, 32'h8000_0000, 32'h55, 32'h0);
        warteAck(z);
        pruefe("beide_latenz", z, 1);
        beende(5);
        pruefe("beide_ausgang", 32'(AusgangPorts), 32'h00_3C55);

        // Input synchroniser on channel 2
        EingangPorts = 24'h3C_0000;
        zugriff("eingang_alt", 1'b1, 1'b0, 32'h8000_0006, 32'h0, 32'h0, 1);
        zugriff("eingang_neu", 1'b1, 1'b0, 32'h8000_0006, 32'h0, 32'h3C, 1);

        // Reset in the middle of a RAM access, late ack afterwards
        ramAktiv = 1'b0;
        RAMDatenBereit = 1'b0;
        RAMDatenGeschrieben = 1'b0;
        LeseDaten = 1'b1;
        DatenAdresse = 32'h0000_0030;
        repeat (2) @(negedge Clock);
        pruefe("mitte_strobe", 32'(RAMLeseDaten), 32'h1);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        LeseDaten = 1'b0;
        Reset = 1'b1;
        pruefe("nach_reset_strobes", {30'd0, RAMLeseDaten, RAMSchreibeDaten}, 32'd0);
        pruefe("nach_reset_ausgang", 32'(AusgangPorts), 32'h0);
        pruefe("nach_reset_fehler", 32'(Fehler), 32'h0);
        RAMDatenBereit = 1'b1;
        RAMDatenLesen  = 32'hCAFE_F00D;
        @(negedge Clock);
        RAMDatenBereit = 1'b0;
        repeat (4) @(negedge Clock);
        pruefe("nach_reset_keine_quittung", {30'd0, DatenGeladen, DatenGespeichert}, 32'd0);
        ramAktiv = 1'b1;
        zugriff("nach_reset_idle", 1'b0, 1'b1, 32'h8000_0000, 32'h11, 32'h0, 1);
        pruefe("nach_reset_k0", 32'(AusgangPorts), 32'h00_0011);

        repeat (2) @(negedge Clock);
        pruefe("scoreboard_leer", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/daten_bus_verteiler.md
Name: daten_bus_verteiler

Overview:
Parametrised data-port interconnect between the CPU data interface and the data RAM plus a bank of memory-mapped I/O channels. It generalises the single LED register to IO_KANAELE output registers with write/set/clear/toggle modes and synchronised input channels. It adds a registered, state-machine-driven handshake and a RAM timeout with a sticky error flag. It sits in the top level between CPU and DatenRAM; the LED bank connects to channel 0.

Parameters:
RAM_ADRESSBITS, 8, word-address bits forwarded to the data RAM
IO_KANAELE, 4, number of I/O channels (1..16)
IO_BREITE, 8, width of each channel (1..32)
IO_BASIS_BIT, 31, address bit that selects the I/O region when 1
TIMEOUT, 255, cycles to wait for a RAM acknowledge before aborting (1..65535)
FEHLER_WERT, 32'hDEADBEEF, read data returned on a RAM timeout

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
LeseDaten  in  1  CPU read request, held until DatenGeladen
SchreibeDaten  in  1  CPU write request, held until DatenGespeichert
DatenAdresse  in  32  CPU word address
DatenRaus  in  32  CPU write data
DatenRein  out  32  read data to CPU, valid while DatenGeladen=1
DatenGeladen  out  1  one-cycle read acknowledge
DatenGespeichert  out  1  one-cycle write acknowledge
RAMLeseDaten  out  1  RAM read strobe
RAMSchreibeDaten  out  1  RAM write strobe
RAMAdresse  out  RAM_ADRESSBITS  RAM word address
RAMDatenSchreiben  out  32  RAM write data
RAMDatenLesen  in  32  RAM read data
RAMDatenBereit  in  1  RAM read done
RAMDatenGeschrieben  in  1  RAM write done
AusgangPorts  out  IO_KANAELE*IO_BREITE  output registers; channel k occupies bits [k*IO_BREITE +: IO_BREITE]
EingangPorts  in  IO_KANAELE*IO_BREITE  asynchronous inputs
Fehler  out  1  sticky RAM-timeout flag

Behaviour:
- Reset (Reset=0 at a rising edge) clears all outputs to 0: state IDLE, AusgangPorts=0, Fehler=0, all strobes and acks 0, DatenRein=0, timeout counter 0, synchronisers 0. This applies from any state; an in-flight RAM access is abandoned, and a late RAM ack is ignored.
- EingangPorts pass through a 2-flop synchroniser per bit; reads see the value 2 cycles old.
- Request = LeseDaten|SchreibeDaten. If both are 1, the access is a write and the read is ignored.
- Decode, latched in IDLE: I/O region when DatenAdresse[IO_BASIS_BIT]=1, else RAM.
  - CB = clog2(IO_KANAELE), minimum 1.
  - kanal = DatenAdresse[CB-1:0].
  - modus = DatenAdresse[CB+1:CB].
- I/O write, modus 00/01/10/11: reg = D / reg|D / reg&~D / reg^D, where D = DatenRaus[IO_BREITE-1:0].
- I/O read: modus 00 returns the output register; 01 returns the synchronised input; 10/11 return 0. Zero-extend to 32 bits.
- A channel index >= IO_KANAELE is still acknowledged: writes are ignored and reads return 0.
- States: IDLE, RAM_WARTEN, ANTWORT, ENDE.
  - IDLE -> ANTWORT on an I/O request. The register update and DatenRein are applied at that edge. The ack is pulsed in ANTWORT, so the ack arrives 1 cycle after the request is seen.
  - IDLE -> RAM_WARTEN on a RAM request. RAMAdresse = DatenAdresse[RAM_ADRESSBITS-1:0] and RAMDatenSchreiben = DatenRaus are registered. Exactly one RAM strobe is driven from the next cycle and held until done.
  - RAM_WARTEN: on RAMDatenBereit (read) or RAMDatenGeschrieben (write), drop the strobe, latch RAMDatenLesen into DatenRein, and go to ANTWORT.
  - RAM_WARTEN timeout: the counter increments each cycle in RAM_WARTEN. When it reaches TIMEOUT, drop the strobe, set Fehler=1, set DatenRein=FEHLER_WERT for reads, and go to ANTWORT. If done and the timeout occur in the same cycle, done wins and Fehler is unchanged.
  - ANTWORT: DatenGeladen or DatenGespeichert = 1 for exactly one cycle, then go to ENDE.
  - ENDE: wait until LeseDaten=0 and SchreibeDaten=0, then go to IDLE. No new access is started until both are low, so there is never a double issue.
- Only Reset clears Fehler. DatenRein holds its value until the next read completes.
- The counter clears on entry to RAM_WARTEN.

Test Plan:
- Reset held 3 cycles mid-RAM access, with RAM ack arriving after release -> strobes 0, no CPU ack, AusgangPorts=0, state IDLE.
- Write 0xA5 to addr 0x8000_0000, then read it back -> DatenGespeichert 1 cycle after the request; AusgangPorts[7:0]=0xA5; read returns 0x0000_00A5.
- Channel 1 = 0xF0. Set 0x0F (addr 0x8000_0005) -> 0xFF. Clear 0x3C (0x8000_0009) -> 0xC3. Toggle 0xFF (0x8000_000D) -> 0x3C. Other channels unchanged.
- RAM write 0x1234_5678 to addr 0x10 with RAM done after 2 cycles; then read -> RAMAdresse=0x10; ack 1 cycle after done; DatenRein=0x1234_5678.
- RAM never acks, TIMEOUT=4 -> DatenGeladen after the timeout; DatenRein=0xDEADBEEF; Fehler=1 and stays 1 through later good accesses.
- LeseDaten and SchreibeDaten both high on channel 0 with D=0x55 -> write performed; only DatenGespeichert pulses. Requests held high for 5 extra cycles -> no second access. EingangPorts change -> visible via modus 01 read after 2 cycles.
